uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART transmitter (TxUnit) among NUM_REQ byte requesters, for example several TX FIFOs or a command engine.
- Accepts one byte from the winning requester and sequences TxUnit through its send/active/done handshake.
- Does not grant the next requester until the current frame has fully completed.
- Sits between the requester FIFOs and TxUnit in the duplex top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT_CYCLES, 65535, clock cycles allowed in START or WAIT_DONE before abort (used only with the optional feature).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe to the granted requester.
- tx_send  out  1  send request to TxUnit.
- tx_data  out  DATA_W  byte presented to TxUnit.
- tx_active  in  1  TxUnit active_flag.
- tx_done  in  1  TxUnit done_flag.
- grant_id  out  $clog2(NUM_REQ)  index of the last/current granted requester.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  16  count of completed frames.
- timeout_flag  out  1  sticky abort indicator.

Behaviour:
- Reset values: state=IDLE, req_ready=0, tx_send=0, tx_data=0, grant_id=NUM_REQ-1, frame_count=0, timeout_flag=0, busy=0. Reset applies in any state, mid-frame included; TxUnit is not aborted.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - Arbitration is combinational. Search from (grant_id+1) mod NUM_REQ upward with wrap; the first set req_valid bit wins.
  - req_ready[winner]=1 in that same cycle only.
  - At the clock edge: tx_data <= req_data[winner], grant_id <= winner, state -> START.
  - With no valid requester, state stays IDLE and req_ready=0.
- START:
  - tx_send=1 (registered, asserted from the first START cycle). It is held while tx_active=0, because TxUnit samples send on its baud clock.
  - When tx_active=1: state -> WAIT_DONE; tx_send=0 from the next cycle.
- WAIT_DONE:
  - tx_send=0 and tx_data held stable.
  - When tx_done=1: frame_count += 1 (wraps 0xFFFF -> 0x0000), state -> GAP.
- GAP:
  - Wait until tx_active=0 and tx_done=0, then state -> IDLE.
  - This guarantees TxUnit is idle before the next grant.
- req_ready is never asserted outside IDLE.
- A requester dropping req_valid outside IDLE has no effect.
- Exactly one byte is accepted per grant.
- Round-robin fairness: with all requesters continuously valid, the grant order is strictly 0,1,...,NUM_REQ-1,0,...
- tx_data changes only on an IDLE grant edge or on reset.
- tx_done asserted while in START (no tx_active seen) is ignored.

Optional Feature:
- Macro UART_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to START and counts each cycle in START and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 in either state: tx_send=0, state -> GAP, timeout_flag <= 1, frame_count not incremented.
  - timeout_flag clears only on reset.
- Not defined: no counter; START and WAIT_DONE wait indefinitely; timeout_flag is tied to 0.

Test Plan:
- Reset check: assert reset for 3 cycles with all req_valid=1 -> req_ready=0, tx_send=0, tx_data=0x00, busy=0, grant_id=3, frame_count=0.
- Single request:
  - Stimulus: req_valid=4'b0100 with requester 2 byte 0xA5; model TxUnit active 5 cycles after send, done 100 cycles later.
  - Response: req_ready=4'b0100 for exactly 1 cycle; tx_data=0xA5; tx_send high until tx_active; frame_count=1.
- Fairness: req_valid=4'b1111 held, bytes 0x10/0x11/0x12/0x13 -> grant_id sequence 0,1,2,3,0 and tx_data sequence 0x10,0x11,0x12,0x13,0x10.
- Back-to-back gap:
  - Stimulus: new req_valid arrives in the same cycle as tx_done; tx_active stays high 2 more cycles.
  - Response: no req_ready until 1 cycle after tx_active=0.
- Mid-frame reset: reset in WAIT_DONE -> next cycle state IDLE, tx_send=0, grant_id=3; the first subsequent grant goes to requester 0.
- Timeout (UART_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: tx_active never asserted.
  - Response: tx_send drops after 16 START cycles; timeout_flag=1; frame_count unchanged at 0; next request is granted normally.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and TxUnit-side handshake bundle for uart_tx_scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_send;
  logic [DATA_W-1:0]              tx_data;
  logic                           tx_active;
  logic                           tx_done;

  modport master (
    input  req_valid, req_data, tx_active, tx_done,
    output req_ready, tx_send, tx_data
  );

  modport slave (
    output req_valid, req_data, tx_active, tx_done,
    input  req_ready, tx_send, tx_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TxUnit among NUM_REQ byte requesters.
// Optional stuck-frame watchdog: define UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_W         = 8,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_scheduler_if.master bus,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic [15:0]         frame_count,
  output logic                timeout_flag
);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            wd_hit;

  // Scan farthest-first from grant_id so the nearest valid requester overwrites.
  always_comb begin
    int idx;
    win_id  = grant_id;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(grant_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[ID_W'(idx)]) begin
        win_id  = ID_W'(idx);
        win_vld = 1'b1;
      end
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;

  assign wd_hit = ((state == START) || (state == WAIT_DONE)) && (wd_cnt == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if ((state_n == START) && (state != START)) wd_cnt <= '0;
      else if ((state == START) || (state == WAIT_DONE)) wd_cnt <= wd_cnt + 16'd1;
      if (wd_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign wd_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // GAP holds off the next grant until TxUnit has dropped both flags.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (win_vld) state_n = START;
      START:     if (wd_hit) state_n = GAP;
                 else if (bus.tx_active) state_n = WAIT_DONE;
      WAIT_DONE: if (wd_hit || bus.tx_done) state_n = GAP;
      GAP:       if (!bus.tx_active && !bus.tx_done) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if ((state == IDLE) && win_vld && !reset) bus.req_ready[win_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.tx_send <= 1'b0;
      bus.tx_data <= '0;
      grant_id    <= ID_W'(NUM_REQ - 1);
      frame_count <= '0;
    end else begin
      bus.tx_send <= (state_n == START);
      if ((state == IDLE) && win_vld) begin
        bus.tx_data <= bus.req_data[win_id];
        grant_id    <= win_id;
      end
      if ((state == WAIT_DONE) && bus.tx_done && !wd_hit) frame_count <= frame_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: requester FIFOs, TxUnit responder model and round-robin reference.
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65535;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] frame_count;
  logic        timeout_flag;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .bus(bus), .grant_id(grant_id), .busy(busy),
    .frame_count(frame_count), .timeout_flag(timeout_flag));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // requester FIFOs
  logic [7:0] rbuf [NUM_REQ][64];
  int rhd  [NUM_REQ];
  int rcnt [NUM_REQ];
  int pushed, granted;

  // reference round-robin pointer and expected completed frames
  int last_gnt, exp_frames;
  logic [NUM_REQ-1:0] exp_ready;

  // TxUnit responder: 0 idle, 1 pre-active, 2 active, 3 done pulse, 4 active tail
  int tu_phase, tu_cnt, act_dly, done_dly, tail;
  bit tu_never, tu_owner;

  logic [NUM_REQ-1:0] obs_ready;
  logic obs_send, obs_active, obs_done, prev_quiet;
  bit   acc;
  int   acc_id;
  logic [7:0] acc_byte;

  task automatic push(input int r, input logic [7:0] b);
    if (rcnt[r] < 64) begin
      rbuf[r][(rhd[r] + rcnt[r]) % 64] = b;
      rcnt[r]++;
      pushed++;
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the models.
  task automatic tick();
    int idx;
    @(negedge clock);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = (rcnt[i] > 0);
      bus.req_data[i]  = (rcnt[i] > 0) ? rbuf[i][rhd[i]] : 8'h00;
    end
    bus.tx_active = (tu_phase >= 2);
    bus.tx_done   = (tu_phase == 3);
    exp_ready = '0;
    idx = -1;
    for (int k = 1; k <= NUM_REQ; k++)
      if (idx < 0 && rcnt[(last_gnt + k) % NUM_REQ] > 0) idx = (last_gnt + k) % NUM_REQ;
    if (idx >= 0 && !reset) exp_ready[idx] = 1'b1;
    #1;
    prev_quiet = !obs_active && !obs_done;
    obs_ready  = bus.req_ready;
    obs_send   = bus.tx_send;
    obs_active = bus.tx_active;
    obs_done   = bus.tx_done;
    acc = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (obs_ready[i] && rcnt[i] > 0) begin
        acc = 1'b1; acc_id = i; acc_byte = rbuf[i][rhd[i]];
        rhd[i] = (rhd[i] + 1) % 64; rcnt[i]--;
        last_gnt = i; granted++;
      end
    case (tu_phase)
      0: if (obs_send) begin tu_phase = 1; tu_cnt = 0; tu_owner = 1'b1; end
      1: if (!tu_never) begin
           if (tu_cnt >= act_dly) begin tu_phase = 2; tu_cnt = 0; end
           else tu_cnt++;
         end
      2: if (tu_cnt >= done_dly) tu_phase = 3; else tu_cnt++;
      3: begin
           if (tu_owner) exp_frames++;
           tu_owner = 1'b0; tu_cnt = 0;
           tu_phase = (tail > 0) ? 4 : 0;
         end
      default: begin tu_cnt++; if (tu_cnt >= tail) tu_phase = 0; end
    endcase
    if (reset) begin last_gnt = NUM_REQ - 1; exp_frames = 0; tu_owner = 1'b0; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin rhd[i] = 0; rcnt[i] = 0; end
    tu_phase = 0; tu_cnt = 0; tu_never = 1'b0; pushed = 0; granted = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    bit empty;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      empty = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (rcnt[i] != 0) empty = 1'b0;
      if (empty && tu_phase == 0 && !busy && obs_ready == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) push(i, 8'(8'h55 + i));
    repeat (3) tick();
    checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", obs_ready); end
    checks++; if (obs_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send got %b exp 0", obs_send); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant_id got %0d exp 3", grant_id); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout_flag got %b exp 0", timeout_flag); end
  endtask

  task automatic test_single();
    int n;
    bit send_bad, ready_bad, ok;
    do_reset();
    act_dly = 5; done_dly = 100; tail = 0;
    push(2, 8'hA5);
    n = 0;
    do begin tick(); n++; end while (obs_ready == 0 && n < 10);
    checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", obs_ready); end
    tick();
    checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_len got %b exp 0000", obs_ready); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data got %h exp a5", bus.tx_data); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id got %0d exp 2", grant_id); end
    checks++; if (obs_send !== 1'b1) begin errors++; $display("FAIL single_send_start got %b exp 1", obs_send); end
    n = 0; send_bad = 1'b0;
    while (!obs_active && n < 50) begin tick(); n++; if (obs_send !== 1'b1) send_bad = 1'b1; end
    checks++; if (send_bad || !obs_active) begin errors++; $display("FAIL single_send_hold got bad=%b active=%b exp bad=0 active=1", send_bad, obs_active); end
    tick();
    checks++; if (obs_send !== 1'b0) begin errors++; $display("FAIL single_send_drop got %b exp 0", obs_send); end
    ready_bad = 1'b0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (obs_ready != 0) ready_bad = 1'b1;
      if (!busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || ready_bad) begin errors++; $display("FAIL single_complete got ok=%b stray_ready=%b exp ok=1 stray_ready=0", ok, ready_bad); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL single_frame_count got %0d exp 1", frame_count); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold got %h exp a5", bus.tx_data); end
  endtask

  task automatic test_fairness();
    int eid [5];
    logic [7:0] edat [5];
    int g, n;
    bit pend, ok;
    eid  = '{0, 1, 2, 3, 0};
    edat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    act_dly = 0; done_dly = 2; tail = 0;
    for (int i = 0; i < NUM_REQ; i++) begin push(i, 8'(8'h10 + i)); push(i, 8'(8'h10 + i)); end
    g = 0; n = 0; pend = 1'b0;
    while ((g < 5 || pend) && n < 500) begin
      tick(); n++;
      if (pend) begin
        checks++; if (bus.tx_data !== edat[g-1]) begin errors++; $display("FAIL fair_data%0d got %h exp %h", g-1, bus.tx_data, edat[g-1]); end
        checks++; if (int'(grant_id) != eid[g-1]) begin errors++; $display("FAIL fair_grant%0d got %0d exp %0d", g-1, grant_id, eid[g-1]); end
        pend = 1'b0;
      end
      if (obs_ready != 0 && g < 5) begin
        checks++; if (obs_ready !== (4'b0001 << eid[g])) begin errors++; $display("FAIL fair_ready%0d got %b exp %b", g, obs_ready, 4'b0001 << eid[g]); end
        g++; pend = 1'b1;
      end
    end
    checks++; if (g != 5) begin errors++; $display("FAIL fair_timeout got %0d grants exp 5", g); end
    drain(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fair_drain got stuck exp idle"); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    logic [7:0] b3;
    do_reset();
    act_dly = 1; done_dly = 4; tail = 2;
    push(1, 8'($urandom));
    b3 = 8'($urandom);
    n = 0;
    while (tu_phase != 3 && n < 100) begin tick(); n++; end
    push(3, b3);
    tick();
    checks++; if (obs_done !== 1'b1 || obs_ready !== 4'b0000) begin errors++; $display("FAIL b2b_done_cycle got done=%b ready=%b exp done=1 ready=0000", obs_done, obs_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (obs_active !== 1'b1 || obs_ready !== 4'b0000) begin errors++; $display("FAIL b2b_tail%0d got active=%b ready=%b exp active=1 ready=0000", i, obs_active, obs_ready); end
    end
    tick();
    checks++; if (obs_active !== 1'b0 || obs_ready !== 4'b0000) begin errors++; $display("FAIL b2b_quiet got active=%b ready=%b exp active=0 ready=0000", obs_active, obs_ready); end
    tick();
    checks++; if (obs_ready !== 4'b1000) begin errors++; $display("FAIL b2b_grant got %b exp 1000", obs_ready); end
    tick();
    checks++; if (bus.tx_data !== b3) begin errors++; $display("FAIL b2b_data got %h exp %h", bus.tx_data, b3); end
    drain(500, ok);
    checks++; if (!ok || frame_count !== 16'd2) begin errors++; $display("FAIL b2b_frames got ok=%b count=%0d exp ok=1 count=2", ok, frame_count); end
  endtask

  task automatic test_mid_reset();
    int n;
    bit ok;
    do_reset();
    act_dly = 0; done_dly = 30; tail = 0;
    push(2, 8'($urandom));
    n = 0;
    while (!obs_active && n < 20) begin tick(); n++; end
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b exp 1", busy); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || obs_send !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%b send=%b exp 0 0", busy, obs_send); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL midrst_grant_id got %0d exp 3", grant_id); end
    reset = 1'b0;
    n = 0;
    while (tu_phase != 0 && n < 100) begin tick(); n++; end
    checks++; if (busy !== 1'b0 || frame_count !== 16'd0) begin errors++; $display("FAIL midrst_stray_done got busy=%b count=%0d exp 0 0", busy, frame_count); end
    for (int i = 0; i < NUM_REQ; i++) push(i, 8'($urandom));
    n = 0;
    do begin tick(); n++; end while (obs_ready == 0 && n < 5);
    checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b exp 0001", obs_ready); end
    drain(1000, ok);
    checks++; if (!ok || frame_count !== 16'd4) begin errors++; $display("FAIL midrst_frames got ok=%b count=%0d exp ok=1 count=4", ok, frame_count); end
  endtask

`ifdef UART_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit ok;
    do_reset();
    act_dly = 0; done_dly = 3; tail = 0; tu_never = 1'b1;
    push(0, 8'h3C);
    n = 0;
    do begin tick(); n++; end while (obs_ready == 0 && n < 5);
    n = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (obs_send) n++; else break; end
    checks++; if (n != 16) begin errors++; $display("FAIL tmo_send_cycles got %0d exp 16", n); end
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", timeout_flag); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL tmo_frame_count got %0d exp 0", frame_count); end
    tu_never = 1'b0; tu_phase = 0; tu_owner = 1'b0;
    push(1, 8'h5A);
    n = 0;
    do begin tick(); n++; end while (obs_ready == 0 && n < 5);
    checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL tmo_next_grant got %b exp 0010", obs_ready); end
    drain(500, ok);
    checks++; if (!ok || frame_count !== 16'd1 || timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_recover got ok=%b count=%0d flag=%b exp 1 1 1", ok, frame_count, timeout_flag); end
  endtask
`endif

  task automatic test_random();
    bit pend, ok, empty;
    int pid;
    logic [7:0] pb;
    do_reset();
    pend = 1'b0; ok = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (tu_phase == 0) begin
        act_dly = $urandom_range(0, 6); done_dly = $urandom_range(0, 12); tail = $urandom_range(0, 2);
      end
      if (c < 2000 && $urandom_range(0, 15) == 0) push($urandom_range(0, NUM_REQ - 1), 8'($urandom));
      tick();
      if (pend) begin
        checks++; if (bus.tx_data !== pb || int'(grant_id) != pid) begin errors++; $display("FAIL rand_accept got data=%h id=%0d exp data=%h id=%0d", bus.tx_data, grant_id, pb, pid); end
        pend = 1'b0;
      end
      if (obs_ready != 0) begin
        checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_arb got %b exp %b", obs_ready, exp_ready); end
        checks++; if (busy !== 1'b0 || obs_active || obs_done || !prev_quiet) begin errors++; $display("FAIL rand_gap got busy=%b active=%b done=%b prevquiet=%b exp 0 0 0 1", busy, obs_active, obs_done, prev_quiet); end
        pend = acc; pb = acc_byte; pid = acc_id;
      end
      empty = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (rcnt[i] != 0) empty = 1'b0;
      if (c >= 2000 && !pend && empty && tu_phase == 0 && !busy && obs_ready == 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain got stuck exp idle"); end
    checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL rand_frames got %0d exp %0d", frame_count, exp_frames); end
    checks++; if (granted != pushed) begin errors++; $display("FAIL rand_grants got %0d exp %0d", granted, pushed); end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.tx_active = 1'b0; bus.tx_done = 1'b0;
    obs_ready = '0; obs_send = 1'b0; obs_active = 1'b0; obs_done = 1'b0; prev_quiet = 1'b1;
    tu_phase = 0; tu_cnt = 0; tu_never = 1'b0; tu_owner = 1'b0;
    act_dly = 0; done_dly = 0; tail = 0;
    last_gnt = NUM_REQ - 1; exp_frames = 0; pushed = 0; granted = 0;
    for (int i = 0; i < NUM_REQ; i++) begin rhd[i] = 0; rcnt[i] = 0; end
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
